vga_pixel_prefetch_fifo: RTL and testbench

//  Sits between the SDRAM read engine (upstream) and VGA colour output (downstream).
//  - Fetch side: requests frame-buffer words one at a time, addressed linearly from 0.
//  - Storage: buffers the returned 16-bit words in a DEPTH-entry FIFO.
//  - Pixel side: hands one RGB444 pixel to the VGA stage per pixel_valid cycle.
//  - Decouples SDRAM activate/read latency from fixed VGA pixel timing.
//  - Flags underflow and overflow.

---
 rtl/vga_pixel_prefetch_fifo.sv | 136 +++++++++++++
 tb/tb_vga_pixel_prefetch_fifo.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_prefetch_fifo.sv
// rtl/vga_pixel_prefetch_fifo.sv - SDRAM-to-VGA pixel prefetch FIFO with single-credit linear fetch
// Optional feature macro: VGA_FIFO_UNDERFLOW_CNT_EN adds a saturating underflow_cnt output.
module vga_pixel_prefetch_fifo #(
  parameter int          DEPTH       = 64,
  parameter int          ADDR_W      = 22,
  parameter int          FRAME_WORDS = 307200,
  parameter logic [11:0] FILL_COLOR  = 12'h6A8
) (
  input  logic                       CLOCK_50,
  input  logic                       reset_n,
  input  logic                       frame_start,
  output logic                       fetch_req,
  output logic [ADDR_W-1:0]          fetch_addr,
  input  logic                       fetch_ack,
  input  logic                       wr_valid,
  input  logic [15:0]                wr_data,
  input  logic                       pixel_valid,
  output logic [11:0]                rgb_out,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       underflow,
`ifdef VGA_FIFO_UNDERFLOW_CNT_EN
  output logic [15:0]                underflow_cnt,
`endif
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CRD_W = LVL_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]       state;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic             discard;
  logic [11:0]      mem [DEPTH];

  logic             pending;
  logic             full;
  logic             empty;
  logic             credit;
  logic             do_write;
  logic             do_pop;
  logic [CRD_W-1:0] credit_sum;
  logic             unused_nibble;

  // The low nibble of each returned word carries no colour.
  assign unused_nibble = ^wr_data[3:0];

  assign pending    = (state == S_WAIT);
  assign full       = (level == LVL_W'(DEPTH));
  assign empty      = (level == '0);
  assign credit_sum = {1'b0, level} + {{LVL_W{1'b0}}, pending};
  assign credit     = (credit_sum < CRD_W'(DEPTH));
  assign do_write   = wr_valid && !discard && !full;
  assign do_pop     = pixel_valid && !empty;
  assign fifo_level = level;

  always_ff @(posedge CLOCK_50) begin
    if (do_write) mem[wr_ptr] <= wr_data[15:4];
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      discard    <= 1'b0;
      fetch_req  <= 1'b0;
      fetch_addr <= '0;
      rgb_out    <= FILL_COLOR;
      underflow  <= 1'b0;
      overflow   <= 1'b0;
`ifdef VGA_FIFO_UNDERFLOW_CNT_EN
      underflow_cnt <= '0;
`endif
    end else if (frame_start) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      fetch_req  <= 1'b0;
      fetch_addr <= '0;
      rgb_out    <= FILL_COLOR;
      // A word already in flight for the old frame must not land in the new one.
      if (pending || (state == S_REQ && fetch_ack)) discard <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (credit) begin
            state     <= S_REQ;
            fetch_req <= 1'b1;
          end
        end
        S_REQ: begin
          if (fetch_ack) begin
            state      <= S_WAIT;
            fetch_req  <= 1'b0;
            fetch_addr <= (fetch_addr == ADDR_W'(FRAME_WORDS - 1)) ? '0 : fetch_addr + 1'b1;
          end
        end
        S_WAIT: begin
          if (wr_valid && !discard) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (wr_valid && discard) discard <= 1'b0;
      if (wr_valid && !discard && full) overflow <= 1'b1;
      if (do_write) wr_ptr <= wr_ptr + 1'b1;

      if (do_pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rgb_out <= mem[rd_ptr];
      end else begin
        rgb_out <= FILL_COLOR;
      end

      if (pixel_valid && empty) begin
        underflow <= 1'b1;
`ifdef VGA_FIFO_UNDERFLOW_CNT_EN
        if (underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
`endif
      end

      if (do_write && !do_pop)      level <= level + 1'b1;
      else if (!do_write && do_pop) level <= level - 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_pixel_prefetch_fifo.sv
// tb/tb_vga_pixel_prefetch_fifo.sv - self-checking bench for vga_pixel_prefetch_fifo
// Two instances: default frame size, and FRAME_WORDS=8 / DEPTH=4 for address wrap.
module tb_vga_pixel_prefetch_fifo;

  localparam logic [11:0] FILL = 12'h6A8;

  logic CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  logic        reset_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        fetch_ack = 1'b0;
  logic        wr_valid = 1'b0;
  logic [15:0] wr_data = '0;
  logic        pixel_valid = 1'b0;
  logic        fetch_req;
  logic [21:0] fetch_addr;
  logic [11:0] rgb_out;
  logic [6:0]  fifo_level;
  logic        underflow;
  logic        overflow;

  logic        f8_start = 1'b0;
  logic        a8_ack = 1'b0;
  logic        w8_valid = 1'b0;
  logic [15:0] w8_data = '0;
  logic        p8_valid = 1'b0;
  logic        r8_req;
  logic [21:0] r8_addr;
  logic [11:0] rgb8;
  logic [2:0]  lvl8;
  logic        und8;
  logic        ovf8;
`ifdef VGA_FIFO_UNDERFLOW_CNT_EN
  logic [15:0] ucnt;
  logic [15:0] ucnt8;
`endif

  vga_pixel_prefetch_fifo dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .frame_start(frame_start),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
    .wr_valid(wr_valid), .wr_data(wr_data), .pixel_valid(pixel_valid),
    .rgb_out(rgb_out), .fifo_level(fifo_level), .underflow(underflow),
`ifdef VGA_FIFO_UNDERFLOW_CNT_EN
    .underflow_cnt(ucnt),
`endif
    .overflow(overflow)
  );

  vga_pixel_prefetch_fifo #(.DEPTH(4), .FRAME_WORDS(8)) dut8 (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .frame_start(f8_start),
    .fetch_req(r8_req), .fetch_addr(r8_addr), .fetch_ack(a8_ack),
    .wr_valid(w8_valid), .wr_data(w8_data), .pixel_valid(p8_valid),
    .rgb_out(rgb8), .fifo_level(lvl8), .underflow(und8),
`ifdef VGA_FIFO_UNDERFLOW_CNT_EN
    .underflow_cnt(ucnt8),
`endif
    .overflow(ovf8)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_q[$];
  logic [21:0] addr_log[$];
  logic        exp_ovf = 1'b0;

  task automatic test_reset();
    repeat (3) @(negedge CLOCK_50);
    n_checks++; if (fetch_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", fetch_req); end
    n_checks++; if (fetch_addr !== 22'd0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", fetch_addr); end
    n_checks++; if (rgb_out !== FILL) begin n_fail++; $display("FAIL reset_rgb got %h exp %h", rgb_out, FILL); end
    n_checks++; if (fifo_level !== 7'd0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
    n_checks++; if ({underflow, overflow} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b exp 00", {underflow, overflow}); end
    reset_n = 1'b1;
  endtask

  // Upstream model: ack two cycles after a request, return the word after a random delay.
  task automatic test_fill();
    bit          acked = 0;
    int          age = 0;
    int          lat = 0;
    int          idx = 0;
    int          cyc;
    logic [15:0] w = '0;
    for (cyc = 0; cyc < 4000 && !(fifo_level == 7'd64 && !acked); cyc++) begin
      @(negedge CLOCK_50);
      fetch_ack = 1'b0;
      wr_valid  = 1'b0;
      if (acked) begin
        if (lat == 0) begin
          wr_valid = 1'b1; wr_data = w; exp_q.push_back(w); acked = 0;
        end else lat--;
      end else if (fetch_req) begin
        age++;
        if (age >= 2) begin
          fetch_ack = 1'b1;
          addr_log.push_back(fetch_addr);
          w = 16'(16'hF000 + (idx << 4) + $urandom_range(0, 15));
          idx++; lat = $urandom_range(0, 3); acked = 1; age = 0;
        end
      end
    end
    n_checks++; if (cyc >= 4000) begin n_fail++; $display("FAIL fill_timeout got %0d cycles exp <4000", cyc); end
    repeat (20) @(negedge CLOCK_50);
    n_checks++; if (fetch_req !== 1'b0) begin n_fail++; $display("FAIL fill_req_idle got %b exp 0", fetch_req); end
    n_checks++; if (fifo_level !== 7'd64) begin n_fail++; $display("FAIL fill_level got %0d exp 64", fifo_level); end
    n_checks++; if (addr_log.size() != 64) begin n_fail++; $display("FAIL fill_nreq got %0d exp 64", addr_log.size()); end
    for (int k = 0; k < addr_log.size(); k++) begin
      n_checks++;
      if (addr_log[k] !== 22'(k)) begin n_fail++; $display("FAIL fill_addr[%0d] got %h exp %h", k, addr_log[k], k); end
    end
  endtask

  task automatic test_overflow();
    wr_valid = 1'b1; wr_data = 16'($urandom);
    @(negedge CLOCK_50);
    wr_valid = 1'b0; exp_ovf = 1'b1;
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    n_checks++; if (fifo_level !== 7'd64) begin n_fail++; $display("FAIL ovf_level got %0d exp 64", fifo_level); end
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL ovf_underflow got %b exp 0", underflow); end
  endtask

  task automatic test_drain();
    int          popped = 0;
    bit          pv;
    logic [15:0] w;
    for (int cyc = 0; cyc < 400 && popped < 64; cyc++) begin
      pv = ($urandom_range(0, 3) != 0);
      pixel_valid = pv;
      @(negedge CLOCK_50);
      pixel_valid = 1'b0;
      if (pv) begin
        w = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0000;
        popped++;
        n_checks++;
        if (rgb_out !== w[15:4]) begin n_fail++; $display("FAIL drain_rgb[%0d] got %h exp %h", popped, rgb_out, w[15:4]); end
      end else begin
        n_checks++;
        if (rgb_out !== FILL) begin n_fail++; $display("FAIL drain_blank got %h exp %h", rgb_out, FILL); end
      end
    end
    n_checks++; if (popped != 64) begin n_fail++; $display("FAIL drain_count got %0d exp 64", popped); end
    n_checks++; if (fifo_level !== 7'd0) begin n_fail++; $display("FAIL drain_level got %0d exp 0", fifo_level); end
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL drain_underflow got %b exp 0", underflow); end
  endtask

  task automatic test_underflow();
    for (int k = 0; k < 3; k++) begin
      pixel_valid = 1'b1;
      @(negedge CLOCK_50);
      n_checks++; if (rgb_out !== FILL) begin n_fail++; $display("FAIL under_rgb[%0d] got %h exp %h", k, rgb_out, FILL); end
    end
    pixel_valid = 1'b0;
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL under_flag got %b exp 1", underflow); end
    n_checks++; if (fifo_level !== 7'd0) begin n_fail++; $display("FAIL under_level got %0d exp 0", fifo_level); end
`ifdef VGA_FIFO_UNDERFLOW_CNT_EN
    n_checks++; if (ucnt !== 16'd3) begin n_fail++; $display("FAIL under_cnt got %0d exp 3", ucnt); end
`endif
  endtask

  task automatic test_frame_flush();
    logic [15:0] w2;
    w2 = {12'h123, 4'($urandom_range(0, 15))};
    n_checks++; if (fetch_req !== 1'b1) begin n_fail++; $display("FAIL flush_pre_req got %b exp 1", fetch_req); end
    fetch_ack = 1'b1;
    @(negedge CLOCK_50);
    fetch_ack = 1'b0; frame_start = 1'b1;
    @(negedge CLOCK_50);
    frame_start = 1'b0; wr_valid = 1'b1; wr_data = 16'($urandom);
    @(negedge CLOCK_50);
    wr_valid = 1'b0;
    n_checks++; if (fifo_level !== 7'd0) begin n_fail++; $display("FAIL flush_level got %0d exp 0", fifo_level); end
    n_checks++; if (overflow !== exp_ovf) begin n_fail++; $display("FAIL flush_ovf got %b exp %b", overflow, exp_ovf); end
    n_checks++; if (fetch_req !== 1'b1) begin n_fail++; $display("FAIL flush_req got %b exp 1", fetch_req); end
    n_checks++; if (fetch_addr !== 22'd0) begin n_fail++; $display("FAIL flush_addr got %h exp 0", fetch_addr); end
    fetch_ack = 1'b1;
    @(negedge CLOCK_50);
    fetch_ack = 1'b0; wr_valid = 1'b1; wr_data = w2;
    @(negedge CLOCK_50);
    wr_valid = 1'b0;
    n_checks++; if (fifo_level !== 7'd1) begin n_fail++; $display("FAIL flush_store_level got %0d exp 1", fifo_level); end
    pixel_valid = 1'b1;
    @(negedge CLOCK_50);
    pixel_valid = 1'b0;
    n_checks++; if (rgb_out !== w2[15:4]) begin n_fail++; $display("FAIL flush_pop_rgb got %h exp %h", rgb_out, w2[15:4]); end
  endtask

  task automatic test_addr_wrap();
    bit          acked = 0;
    logic [21:0] a8[$];
    int          cyc;
    p8_valid = 1'b1;
    for (cyc = 0; cyc < 300 && a8.size() < 10; cyc++) begin
      @(negedge CLOCK_50);
      a8_ack = 1'b0; w8_valid = 1'b0;
      if (acked) begin
        w8_valid = 1'b1; w8_data = 16'($urandom); acked = 0;
      end else if (r8_req) begin
        a8_ack = 1'b1; a8.push_back(r8_addr); acked = 1;
      end
    end
    @(negedge CLOCK_50);
    a8_ack = 1'b0; w8_valid = 1'b0; p8_valid = 1'b0;
    n_checks++; if (a8.size() != 10) begin n_fail++; $display("FAIL wrap_count got %0d exp 10", a8.size()); end
    for (int k = 0; k < a8.size(); k++) begin
      n_checks++;
      if (a8[k] !== 22'(k % 8)) begin n_fail++; $display("FAIL wrap_addr[%0d] got %0d exp %0d", k, a8[k], k % 8); end
    end
  endtask

  task automatic test_async_reset();
    n_checks++; if (fetch_req !== 1'b1) begin n_fail++; $display("FAIL areset_pre_req got %b exp 1", fetch_req); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (fetch_req !== 1'b0) begin n_fail++; $display("FAIL areset_req got %b exp 0", fetch_req); end
    n_checks++; if (rgb_out !== FILL) begin n_fail++; $display("FAIL areset_rgb got %h exp %h", rgb_out, FILL); end
    n_checks++; if ({underflow, overflow} !== 2'b00) begin n_fail++; $display("FAIL areset_flags got %b exp 00", {underflow, overflow}); end
    n_checks++; if (fifo_level !== 7'd0) begin n_fail++; $display("FAIL areset_level got %0d exp 0", fifo_level); end
    @(negedge CLOCK_50);
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_underflow();
    test_frame_flush();
    test_async_reset();
    test_addr_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
